// File: rtl/hack_cpu_core.sv
// Hack CPU core: instruction decode, internal alu, and the A/D/PC register file.
// outM/writeM/addressM are combinational and A/D/pc update one edge later; stall=1 holds all state and suppresses writeM.
module hack_cpu_core #(
    parameter int                ADDR_W   = 15,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic [15:0]       instruction,
    input  logic [15:0]       inM,
    output logic [15:0]       outM,
    output logic              writeM,
    output logic [ADDR_W-1:0] addressM,
    output logic [ADDR_W-1:0] pc
);

    typedef struct packed {
        logic zx;
        logic nx;
        logic zy;
        logic ny;
        logic f;
        logic no;
    } alu_ctrl_t;

    typedef struct packed {
        logic      is_c;
        logic      sel_m;
        alu_ctrl_t alu;
        logic      dst_a;
        logic      dst_d;
        logic      dst_m;
        logic      jmp_lt;
        logic      jmp_eq;
        logic      jmp_gt;
    } dec_t;

    // Bits [14:13] of a C-instruction carry no meaning and are dropped here.
    function automatic dec_t decode(input logic [15:0] instr);
        dec_t d;
        d.is_c   = instr[15];
        d.sel_m  = instr[12];
        d.alu    = alu_ctrl_t'(instr[11:6]);
        d.dst_a  = instr[5];
        d.dst_d  = instr[4];
        d.dst_m  = instr[3];
        d.jmp_lt = instr[2];
        d.jmp_eq = instr[1];
        d.jmp_gt = instr[0];
        return d;
    endfunction

    logic [15:0]       a_reg;
    logic [15:0]       d_reg;
    logic [ADDR_W-1:0] pc_reg;

    dec_t              dec;
    logic [15:0]       alu_y;
    logic [15:0]       x_z;
    logic [15:0]       x_n;
    logic [15:0]       y_z;
    logic [15:0]       y_n;
    logic [15:0]       alu_f;
    logic [15:0]       alu_out;
    logic              alu_zr;
    logic              alu_ng;
    logic              take_jump;
    logic [ADDR_W-1:0] pc_next;

    assign dec   = decode(instruction);
    assign alu_y = dec.sel_m ? inM : a_reg;

    always_comb begin
        x_z     = dec.alu.zx ? 16'h0000 : d_reg;
        x_n     = dec.alu.nx ? ~x_z : x_z;
        y_z     = dec.alu.zy ? 16'h0000 : alu_y;
        y_n     = dec.alu.ny ? ~y_z : y_z;
        alu_f   = dec.alu.f ? (x_n + y_n) : (x_n & y_n);
        alu_out = dec.alu.no ? ~alu_f : alu_f;
    end

    assign alu_zr = (alu_out == 16'h0000);
    assign alu_ng = alu_out[15];

    // Jump target is the A value before this edge, even when the same instruction writes A.
    assign take_jump = dec.is_c & ((dec.jmp_lt & alu_ng) |
                                   (dec.jmp_eq & alu_zr) |
                                   (dec.jmp_gt & ~alu_zr & ~alu_ng));
    assign pc_next   = take_jump ? a_reg[ADDR_W-1:0] : pc_reg + ADDR_W'(1);

    assign outM     = alu_out;
    assign writeM   = dec.is_c & dec.dst_m & ~stall & ~reset;
    assign addressM = a_reg[ADDR_W-1:0];
    assign pc       = pc_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_reg  <= 16'h0000;
            d_reg  <= 16'h0000;
            pc_reg <= RESET_PC;
        end else if (!stall) begin
            if (!dec.is_c) begin
                a_reg <= instruction;
            end else if (dec.dst_a) begin
                a_reg <= alu_out;
            end
            if (dec.is_c && dec.dst_d) begin
                d_reg <= alu_out;
            end
            pc_reg <= pc_next;
        end
    end

endmodule

// File: tb/tb_hack_cpu_core.sv
// Bench for hack_cpu_core: directed program snippets then random instructions,
// each cycle's expected outputs queued by the driver and popped by an independent monitor.
module tb_hack_cpu_core;

    localparam int          ADDR_W   = 15;
    localparam logic [14:0] RESET_PC = 15'h0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic [15:0] instruction;
    logic [15:0] inM;
    logic [15:0] outM;
    logic        writeM;
    logic [14:0] addressM;
    logic [14:0] pc;

    always #5 clk = ~clk;

    hack_cpu_core #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .instruction (instruction),
        .inM         (inM),
        .outM        (outM),
        .writeM      (writeM),
        .addressM    (addressM),
        .pc          (pc)
    );

    typedef struct {
        string       name;
        bit          chk_out;
        logic [15:0] out;
        logic        wr;
        logic [14:0] addr;
        logic [14:0] pc;
    } exp_t;

    exp_t        exp_q[$];
    int          errors = 0;
    int          checks = 0;
    logic [15:0] ma;
    logic [15:0] md;
    int          mpc;
    logic [5:0]  codes [18] = '{6'b101010, 6'b111111, 6'b111010, 6'b001100, 6'b110000,
                                6'b001101, 6'b110001, 6'b001111, 6'b110011, 6'b011111,
                                6'b110111, 6'b001110, 6'b110010, 6'b000010, 6'b010011,
                                6'b000111, 6'b000000, 6'b010101};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Hack assembly meaning of each comp mnemonic, x = D, y = A or M.
    function automatic logic [15:0] comp(input logic [5:0] c, input logic [15:0] x, input logic [15:0] y);
        case (c)
            6'b101010: return 16'd0;
            6'b111111: return 16'd1;
            6'b111010: return 16'hFFFF;
            6'b001100: return x;
            6'b110000: return y;
            6'b001101: return ~x;
            6'b110001: return ~y;
            6'b001111: return 16'd0 - x;
            6'b110011: return 16'd0 - y;
            6'b011111: return x + 16'd1;
            6'b110111: return y + 16'd1;
            6'b001110: return x - 16'd1;
            6'b110010: return y - 16'd1;
            6'b000010: return x + y;
            6'b010011: return x - y;
            6'b000111: return y - x;
            6'b000000: return x & y;
            6'b010101: return x | y;
            default:   return 16'hxxxx;
        endcase
    endfunction

    task automatic step(input logic [15:0] ins, input logic [15:0] m, input bit stl,
                        input bit rst, input string name, input bit mid_rst = 1'b0);
        exp_t        e;
        logic [15:0] r;
        logic [14:0] tgt;
        bit          zero;
        bit          neg;
        bit          jmp;
        @(negedge clk);
        instruction = ins;
        inM         = m;
        stall       = stl;
        reset       = rst;
        if (rst) begin
            ma  = 16'h0000;
            md  = 16'h0000;
            mpc = int'(RESET_PC);
        end
        r         = comp(ins[11:6], md, ins[12] ? m : ma);
        e.name    = name;
        e.chk_out = ins[15];
        e.out     = r;
        e.wr      = ins[15] && ins[3] && !stl && !rst;
        e.addr    = ma[14:0];
        e.pc      = mpc[14:0];
        exp_q.push_back(e);
        if (mid_rst) begin
            #3 reset = 1'b1;
            #1;
            chk({name, "/async_pc"}, 32'(pc), 32'(RESET_PC));
            chk({name, "/async_addressM"}, 32'(addressM), 32'd0);
            chk({name, "/async_writeM"}, 32'(writeM), 32'd0);
            ma  = 16'h0000;
            md  = 16'h0000;
            mpc = int'(RESET_PC);
        end else if (!rst && !stl) begin
            if (!ins[15]) begin
                ma  = ins;
                mpc = (mpc + 1) % 32768;
            end else begin
                zero = (r == 16'h0000);
                neg  = $signed(r) < 0;
                jmp  = (ins[2] && neg) || (ins[1] && zero) || (ins[0] && !zero && !neg);
                tgt  = ma[14:0];
                if (ins[5]) ma = r;
                if (ins[4]) md = r;
                mpc = jmp ? int'(tgt) : (mpc + 1) % 32768;
            end
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (e.chk_out) chk({e.name, "/outM"}, 32'(outM), 32'(e.out));
                chk({e.name, "/writeM"}, 32'(writeM), 32'(e.wr));
                chk({e.name, "/addressM"}, 32'(addressM), 32'(e.addr));
                chk({e.name, "/pc"}, 32'(pc), 32'(e.pc));
            end
        end
    end

    initial begin
        logic [15:0] ins;
        bit          stl;
        bit          rst;
        reset       = 1'b1;
        stall       = 1'b0;
        instruction = 16'h0000;
        inM         = 16'h0000;

        step(16'h0000, 16'h0, 0, 1, "reset");
        step(16'h1234, 16'h0, 0, 0, "a_1234");
        step(16'hEC10, 16'h0, 0, 0, "d_eq_a");
        step(16'hE300, 16'h0, 0, 0, "read_d");

        step(16'h0005, 16'h0, 0, 0, "a_5");
        step(16'hEC10, 16'h0, 0, 0, "d_5");
        step(16'h0064, 16'h0, 0, 0, "a_100");
        step(16'hE7C8, 16'h0, 0, 0, "m_d_plus_1");
        step(16'hE300, 16'h0, 0, 0, "d_still_5");

        step(16'hEA90, 16'h0, 0, 0, "d_zero");
        step(16'h0028, 16'h0, 0, 0, "a_40");
        step(16'hEA82, 16'h0, 0, 0, "jeq_taken");
        step(16'h0000, 16'h0, 0, 0, "at_40");
        step(16'hEE90, 16'h0, 0, 0, "d_minus1");
        step(16'hE301, 16'h0, 0, 0, "jgt_not_taken");
        step(16'h0000, 16'h0, 0, 0, "after_jgt");

        step(16'h0007, 16'h0, 0, 0, "a_7");
        step(16'hFCA8, 16'h3, 0, 0, "am_m_minus_1");
        step(16'hEC10, 16'h0, 0, 0, "a_now_2");

        step(16'h0010, 16'h0, 0, 0, "a_16");
        repeat (3) step(16'hE7C8, 16'h0, 1, 0, "stalled_write");
        step(16'hE7C8, 16'h0, 0, 0, "unstalled_write");
        step(16'hE300, 16'h0, 0, 0, "d_after_stall");

        step(16'h7FFF, 16'h0, 0, 0, "a_7fff");
        step(16'hEA87, 16'h0, 0, 0, "jmp_7fff");
        step(16'h0001, 16'h0, 0, 0, "at_7fff");
        step(16'h0000, 16'h0, 0, 0, "pc_wrapped");

        step(16'h0030, 16'h0, 0, 0, "a_48");
        step(16'hE7C8, 16'h0, 0, 0, "mid_reset", 1'b1);
        step(16'hE7C8, 16'h0, 0, 1, "held_reset");
        step(16'h0001, 16'h0, 0, 0, "post_reset");

        for (int i = 0; i < 600; i++) begin
            stl = ($urandom_range(0, 4) == 0);
            rst = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 2) == 0)
                ins = {1'b0, 15'($urandom)};
            else
                ins = {1'b1, 2'($urandom), 1'($urandom), codes[$urandom_range(0, 17)], 6'($urandom)};
            step(ins, 16'($urandom), stl, rst, "rand");
        end

        repeat (3) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
